// File: rtl/mulcheck_if.sv
// mulcheck_if: byte-serial link between the multiply self-test initiator
// and the UART transmit/receive endpoints.
//   m_stb/m_dat/m_rdy : operand bytes flowing toward transmit
//   s_stb/s_dat/s_rdy : product bytes arriving from receive
// master = the initiator (mulcheck), slave = the link endpoint side.
interface mulcheck_if;
    logic       m_stb;
    logic [7:0] m_dat;
    logic       m_rdy;
    logic       s_stb;
    logic [7:0] s_dat;
    logic       s_rdy;

    modport master (
        output m_stb, m_dat, s_rdy,
        input  m_rdy, s_stb, s_dat
    );

    modport slave (
        input  m_stb, m_dat, s_rdy,
        output m_rdy, s_stb, s_dat
    );
endinterface

// File: rtl/mulcheck.sv
// mulcheck: self-test initiator for the byte-serial multiply link.
// Walks idx from 0 to COUNT-1, sends a=idx[7:0] then b=idx[15:8], waits
// for the 16-bit product (low byte first), and counts mismatches against
// the locally computed a*b.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   link      : mulcheck_if.master (operand out, result in)
//   go        : start-run pulse, honoured only in IDLE or DONE
//   busy      : run in progress
//   done      : run finished, held until the next go
//   tmo       : run aborted because a result byte never arrived
//   err_cnt   : saturating mismatch count
//   fail_idx  : index of the first mismatch (valid when err_cnt != 0)
module mulcheck #(
    parameter int COUNT   = 65536,
    parameter int TIMEOUT = 12000000
) (
    input  logic               clk,
    input  logic               rst,
    mulcheck_if.master         link,
    input  logic               go,
    output logic               busy,
    output logic               done,
    output logic               tmo,
    output logic [15:0]        err_cnt,
    output logic [15:0]        fail_idx
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        RECV_LO,
        RECV_HI,
        CHECK,
        DONE
    } state_t;

    localparam logic [16:0] LAST_IDX = 17'(COUNT - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    logic [16:0] idx;
    logic [7:0]  lo_byte;
    logic [7:0]  hi_byte;
    logic [31:0] tmo_cnt;

    logic        m_xfer;
    logic        s_xfer;
    logic        tmo_hit;
    logic [16:0] idx_next;
    logic [15:0] expected;

    assign m_xfer   = link.m_stb & link.m_rdy;
    assign s_xfer   = link.s_stb & link.s_rdy;
    assign idx_next = idx + 17'd1;
    assign expected = {8'h00, idx[7:0]} * {8'h00, idx[15:8]};
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST) && !s_xfer;

    // Single state machine; every output is a register updated here so the
    // link sees glitch-free, edge-aligned handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            lo_byte     <= '0;
            hi_byte     <= '0;
            tmo_cnt     <= '0;
            link.m_stb  <= 1'b0;
            link.m_dat  <= '0;
            link.s_rdy  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tmo         <= 1'b0;
            err_cnt     <= '0;
            fail_idx    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state      <= SEND_A;
                        idx        <= '0;
                        err_cnt    <= '0;
                        fail_idx   <= '0;
                        tmo        <= 1'b0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        link.m_stb <= 1'b1;
                        link.m_dat <= 8'h00;
                    end
                end
                SEND_A: begin
                    if (m_xfer) begin
                        state      <= SEND_B;
                        link.m_dat <= idx[15:8];
                    end
                end
                SEND_B: begin
                    if (m_xfer) begin
                        state      <= RECV_LO;
                        link.m_stb <= 1'b0;
                        link.s_rdy <= 1'b1;
                        tmo_cnt    <= '0;
                    end
                end
                RECV_LO: begin
                    if (s_xfer) begin
                        state   <= RECV_HI;
                        lo_byte <= link.s_dat;
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        state      <= DONE;
                        link.s_rdy <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        tmo        <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RECV_HI: begin
                    if (s_xfer) begin
                        state      <= CHECK;
                        hi_byte    <= link.s_dat;
                        link.s_rdy <= 1'b0;
                    end else if (tmo_hit) begin
                        state      <= DONE;
                        link.s_rdy <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        tmo        <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                CHECK: begin
                    if ({hi_byte, lo_byte} != expected) begin
                        if (err_cnt != 16'hFFFF) begin
                            err_cnt <= err_cnt + 16'd1;
                        end
                        if (err_cnt == 16'h0000) begin
                            fail_idx <= idx[15:0];
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state      <= SEND_A;
                        idx        <= idx_next;
                        link.m_stb <= 1'b1;
                        link.m_dat <= idx_next[7:0];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mulcheck.sv
// tb_mulcheck: bench for mulcheck. A behavioural responder plays the
// multiply link (collects a,b, returns a*b low byte first), optionally
// stalling, corrupting or dropping bytes; the expected operand stream and
// final counters come from plain arithmetic over the transaction index.
module tb_mulcheck;
    localparam int N   = 258;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        busy;
    logic        done;
    logic        tmo;
    logic [15:0] err_cnt;
    logic [15:0] fail_idx;

    mulcheck_if link();

    mulcheck #(.COUNT(N), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .link     (link.master),
        .go       (go),
        .busy     (busy),
        .done     (done),
        .tmo      (tmo),
        .err_cnt  (err_cnt),
        .fail_idx (fail_idx)
    );

    always #5 clk = ~clk;

    int          checks;
    int          failures;
    int          cyc;
    int          tx_idx;
    bit          phase;
    bit          res_valid;
    bit          res_half;
    logic [15:0] res_val;
    int          res_idx;
    int          completed;
    bit          prev_stall;
    logic [7:0]  prev_dat;
    bit          stall_en;
    bit          hold_b;
    bit          drop_hi;
    bit          corrupt [N];
    logic [7:0]  sent_q [$];
    int          lo_cyc;
    int          go_at;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        tx_idx     = 0;
        phase      = 1'b0;
        res_valid  = 1'b0;
        res_half   = 1'b0;
        completed  = 0;
        prev_stall = 1'b0;
        sent_q.delete();
    endtask

    // One clock cycle: at the falling edge, check the link against the
    // model and decide the responder's handshake for the next rising edge.
    task automatic tick();
        logic [15:0] ti;
        logic [15:0] pa;
        logic [15:0] pb;
        logic [7:0]  exp_byte;
        @(negedge clk);
        cyc++;
        if (rst) begin
            clear_model();
            link.m_rdy = 1'b0;
            link.s_stb = 1'b0;
            return;
        end
        if (prev_stall) begin
            check_output("m_stb_hold", link.m_stb, 1);
            check_output("m_dat_hold", link.m_dat, prev_dat);
        end
        if (res_valid) begin
            check_output("one_outstanding", link.m_stb, 0);
        end
        link.m_rdy = (hold_b && phase) ? 1'b0 :
                     (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (link.m_stb && link.m_rdy) begin
            ti       = 16'(tx_idx);
            exp_byte = phase ? ti[15:8] : ti[7:0];
            check_output("op_byte", link.m_dat, exp_byte);
            sent_q.push_back(link.m_dat);
            if (phase) begin
                pa        = {8'h00, ti[7:0]};
                pb        = {8'h00, ti[15:8]};
                res_val   = pa * pb;
                if (corrupt[tx_idx]) res_val = res_val ^ 16'h0100;
                res_valid = 1'b1;
                res_half  = 1'b0;
                res_idx   = tx_idx;
                tx_idx++;
            end
            phase = ~phase;
        end
        prev_stall = link.m_stb && !link.m_rdy;
        prev_dat   = link.m_dat;
        if (res_valid) begin
            link.s_dat = res_half ? res_val[15:8] : res_val[7:0];
            link.s_stb = (drop_hi && res_idx == 0 && res_half) ? 1'b0 :
                         (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (link.s_stb && link.s_rdy) begin
                if (res_half) begin
                    res_valid = 1'b0;
                    completed++;
                end else begin
                    res_half = 1'b1;
                    lo_cyc   = cyc;
                end
            end
        end else begin
            link.s_stb = 1'b0;
            link.s_dat = 8'h00;
        end
    endtask

    task automatic start_run();
        clear_model();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int elapsed);
        elapsed = 0;
        while (!done && elapsed < budget) begin
            go = (elapsed == go_at);
            tick();
            elapsed++;
        end
        go = 1'b0;
        if (!done) check_output("done_budget", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_m_stb"}, link.m_stb, 0);
        check_output({tag, "_m_dat"}, link.m_dat, 0);
        check_output({tag, "_s_rdy"}, link.s_rdy, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_tmo"}, tmo, 0);
        check_output({tag, "_err_cnt"}, err_cnt, 0);
        check_output({tag, "_fail_idx"}, fail_idx, 0);
    endtask

    task automatic check_clean_run(input string tag);
        check_output({tag, "_done"}, done, 1);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_tmo"}, tmo, 0);
        check_output({tag, "_err_cnt"}, err_cnt, 0);
        check_output({tag, "_completed"}, completed, N);
        check_output({tag, "_bytes"}, sent_q.size(), 2 * N);
    endtask

    task automatic apply_stimulus();
        int elapsed;
        int exp_err;
        int exp_first;

        // Ideal responder with a go pulse injected mid-run.
        go_at = 400;
        start_run();
        wait_done(3000, elapsed);
        go_at = -1;
        check_output("ideal_cycles", elapsed, 1290);
        check_clean_run("ideal");
        if (sent_q.size() == 2 * N) begin
            check_output("first_a", sent_q[0], 8'h00);
            check_output("first_b", sent_q[1], 8'h00);
            check_output("last_a", sent_q[2*N-2], 8'h01);
            check_output("last_b", sent_q[2*N-1], 8'h01);
        end

        // Corrupted products at idx 5 and 9.
        corrupt[5] = 1'b1;
        corrupt[9] = 1'b1;
        start_run();
        wait_done(3000, elapsed);
        exp_err   = 0;
        exp_first = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (corrupt[i]) begin
                exp_err++;
                exp_first = i;
            end
        end
        check_output("corrupt_err_model", err_cnt, exp_err);
        check_output("corrupt_first_model", fail_idx, exp_first);
        check_output("corrupt_err_lit", err_cnt, 2);
        check_output("corrupt_first_lit", fail_idx, 5);
        check_output("corrupt_done", done, 1);
        corrupt[5] = 1'b0;
        corrupt[9] = 1'b0;

        // go while in DONE clears counters and restarts.
        start_run();
        check_output("rego_err_cnt", err_cnt, 0);
        check_output("rego_fail_idx", fail_idx, 0);
        check_output("rego_done", done, 0);
        check_output("rego_busy", busy, 1);
        wait_done(3000, elapsed);
        check_clean_run("rego");

        // Random stalls on both sides.
        stall_en = 1'b1;
        start_run();
        wait_done(8000, elapsed);
        stall_en = 1'b0;
        check_clean_run("stall");

        // High byte of idx 0 never arrives.
        drop_hi = 1'b1;
        start_run();
        wait_done(200, elapsed);
        drop_hi = 1'b0;
        check_output("tmo_flag", tmo, 1);
        check_output("tmo_done", done, 1);
        check_output("tmo_busy", busy, 0);
        check_output("tmo_err_cnt", err_cnt, 0);
        check_output("tmo_latency", cyc - (lo_cyc + 1), TMO);

        // Reset while parked in SEND_B.
        start_run();
        repeat (17) tick();
        hold_b = 1'b1;
        elapsed = 0;
        while (!(phase && link.m_stb) && elapsed < 20) begin
            tick();
            elapsed++;
        end
        check_output("park_send_b", phase && link.m_stb, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst    = 1'b0;
        hold_b = 1'b0;
        tick();
        check_reset_outputs("postrst");
        start_run();
        wait_done(3000, elapsed);
        check_clean_run("restart");
        if (sent_q.size() >= 2) begin
            check_output("restart_a0", sent_q[0], 8'h00);
            check_output("restart_b0", sent_q[1], 8'h00);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        lo_cyc     = 0;
        go_at      = -1;
        stall_en   = 1'b0;
        hold_b     = 1'b0;
        drop_hi    = 1'b0;
        for (int i = 0; i < N; i++) corrupt[i] = 1'b0;
        clear_model();
        rst        = 1'b1;
        go         = 1'b0;
        link.m_rdy = 1'b0;
        link.s_stb = 1'b0;
        link.s_dat = 8'h00;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        apply_stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
